// File: rtl/alu_flags_writeback_pkg.sv
// Types shared by the execute-to-writeback stage and its FIFO.
package alu_flags_writeback_pkg;

  localparam int unsigned ULONG_W = 64;

  typedef logic [ULONG_W-1:0] ulong_t;

  typedef struct packed {
    logic negitive;
    logic carry;
    logic zero;
  } alu_flags_t;

  typedef enum logic [0:0] {
    EXC_IDLE = 1'b0,
    EXC_TRAP = 1'b1
  } exc_state_t;

endpackage

// File: rtl/instructions_pkg.sv
// Opcode encoding shared by the ALU and the stages around it.
package instructions;

  typedef enum logic [3:0] {
    NOP  = 4'd0,
    INC  = 4'd1,
    DEC  = 4'd2,
    ADD  = 4'd3,
    SUB  = 4'd4,
    MUL  = 4'd5,
    UDIV = 4'd6,
    SDIV = 4'd7,
    UMOD = 4'd8,
    SMOD = 4'd9
  } opcode_t;

  // Only the divide family can raise divByZero; the flag is ignored elsewhere.
  function automatic logic is_div_op(input opcode_t op);
    case (op)
      UDIV, SDIV, UMOD, SMOD: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_flags_writeback_chk.sv
// Invariant checkers for the writeback FIFO and the stage's issue handshake.
module wb_fifo_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count == '0)));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

endmodule

module alu_flags_writeback_chk (
  input logic clk,
  input logic rst_n,
  input logic pushValid,
  input logic pushReady,
  input logic inReady,
  input logic excPending
);

  a_push_never_dropped: assert property (@(posedge clk) disable iff (!rst_n)
    pushValid |-> pushReady);

  a_stall_during_trap: assert property (@(posedge clk) disable iff (!rst_n)
    excPending |-> !inReady);

endmodule

// File: rtl/alu_flags_writeback_fifo.sv
// Small power-of-two valid/ready FIFO with a registered head (1-cycle first-word latency).
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 69
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pushValid,
  output logic                       pushReady,
  input  logic [WIDTH-1:0]           pushData,
  output logic                       popValid,
  input  logic                       popReady,
  output logic [WIDTH-1:0]           popData,
  output logic [$clog2(DEPTH):0]     countNext
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [PTR_W-1:0] rdPtrNext_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] countNext_s;
  logic             popValid_r;
  logic [WIDTH-1:0] popData_r;
  logic [WIDTH-1:0] headNext_s;
  logic             push_s;
  logic             pop_s;

  assign pushReady = (count_r != CNT_W'(DEPTH));
  assign push_s    = pushValid & pushReady;
  assign pop_s     = popValid_r & popReady;
  assign popValid  = popValid_r;
  assign popData   = popData_r;
  assign countNext = countNext_s;

  // Next occupancy and read pointer after this cycle's push/pop.
  always_comb begin
    countNext_s = count_r;
    rdPtrNext_s = rdPtr_r;
    case ({push_s, pop_s})
      2'b10:   countNext_s = count_r + CNT_W'(1);
      2'b01:   countNext_s = count_r - CNT_W'(1);
      default: countNext_s = count_r;
    endcase
    if (pop_s) begin
      rdPtrNext_s = rdPtr_r + PTR_W'(1);
    end else begin
      rdPtrNext_s = rdPtr_r;
    end
  end

  // The head register must see a word written this cycle if it lands in the next read slot.
  always_comb begin
    headNext_s = popData_r;
    if (countNext_s == '0) begin
      headNext_s = popData_r;
    end else if (push_s && (rdPtrNext_s == wrPtr_r)) begin
      headNext_s = pushData;
    end else begin
      headNext_s = mem_r[rdPtrNext_s];
    end
  end

  // Storage, pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wrPtr_r    <= '0;
      rdPtr_r    <= '0;
      count_r    <= '0;
      popValid_r <= 1'b0;
      popData_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wrPtr_r] <= pushData;
        wrPtr_r        <= wrPtr_r + PTR_W'(1);
      end
      rdPtr_r    <= rdPtrNext_s;
      count_r    <= countNext_s;
      popValid_r <= (countNext_s != '0);
      popData_r  <= headNext_s;
    end
  end

  wb_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );

endmodule

// File: rtl/alu_flags_writeback.sv
// Execute-to-writeback stage: commits ALU flags, queues results for the register
// file and turns divide-by-zero into a sticky trap that stalls issue.
module alu_flags_writeback
  import alu_flags_writeback_pkg::*;
  import instructions::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  opcode_t              in_op,
  input  logic [REG_IDX_W-1:0] in_dest,
  input  ulong_t               in_result,
  input  logic                 in_divByZero,
  input  logic                 in_zero,
  input  logic                 in_carry,
  input  logic                 in_negitive,
  output logic                 carry_q,
  output logic [2:0]           flags_q,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [REG_IDX_W-1:0] wb_dest,
  output ulong_t               wb_data,
  output logic                 exc_pending,
  input  logic                 exc_ack
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned WIDTH = REG_IDX_W + ULONG_W;

  exc_state_t       excState_r;
  logic             excPending_r;
  logic             inReady_r;
  alu_flags_t       flags_r;
  logic             accept_s;
  logic             divTrap_s;
  logic             push_s;
  logic             fifoPushReady_s;
  logic [CNT_W-1:0] fifoCountNext_s;
  logic             spaceNext_s;
  logic [WIDTH-1:0] fifoPopData_s;

  assign accept_s    = in_valid & inReady_r;
  assign divTrap_s   = accept_s & is_div_op(in_op) & in_divByZero;
  assign push_s      = accept_s & (in_op != NOP) & ~divTrap_s;
  assign spaceNext_s = (fifoCountNext_s < CNT_W'(DEPTH));

  assign in_ready    = inReady_r;
  assign exc_pending = excPending_r;
  assign flags_q     = flags_r;
  assign carry_q     = flags_r.carry;
  assign {wb_dest, wb_data} = fifoPopData_s;

  // Exception FSM; issue readiness is decided here so it never depends on wb_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      excState_r   <= EXC_IDLE;
      excPending_r <= 1'b0;
      inReady_r    <= 1'b1;
    end else begin
      case (excState_r)
        EXC_IDLE: begin
          if (divTrap_s) begin
            excState_r   <= EXC_TRAP;
            excPending_r <= 1'b1;
            inReady_r    <= 1'b0;
          end else begin
            excState_r   <= EXC_IDLE;
            excPending_r <= 1'b0;
            inReady_r    <= spaceNext_s;
          end
        end
        EXC_TRAP: begin
          if (exc_ack) begin
            excState_r   <= EXC_IDLE;
            excPending_r <= 1'b0;
            inReady_r    <= spaceNext_s;
          end else begin
            excState_r   <= EXC_TRAP;
            excPending_r <= 1'b1;
            inReady_r    <= 1'b0;
          end
        end
        default: begin
          excState_r   <= EXC_IDLE;
          excPending_r <= 1'b0;
          inReady_r    <= 1'b0;
        end
      endcase
    end
  end

  // Architectural flags commit only for ops that also write back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= '0;
    end else if (push_s) begin
      flags_r <= '{negitive: in_negitive, carry: in_carry, zero: in_zero};
    end else begin
      flags_r <= flags_r;
    end
  end

  wb_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushValid (push_s),
    .pushReady (fifoPushReady_s),
    .pushData  ({in_dest, in_result}),
    .popValid  (wb_valid),
    .popReady  (wb_ready),
    .popData   (fifoPopData_s),
    .countNext (fifoCountNext_s)
  );

  alu_flags_writeback_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .pushValid  (push_s),
    .pushReady  (fifoPushReady_s),
    .inReady    (inReady_r),
    .excPending (excPending_r)
  );

endmodule
